response_checker: RTL
=====================

RESPONSE_CHECKER -- requirements
Module: response_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 9: clock cycles from vector acceptance to the DUT-output sample; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of the pass and fail counters.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 vec_valid  input  1  a stimulus vector is offered.
REQ-006 vec_ready  output  1  checker can accept a vector.
REQ-007 vec_a, vec_b, vec_c  input  1 each  stimulus bits driven into the combinational DUT.
REQ-008 dut_out  input  1  DUT response under check.
REQ-009 clear  input  1  synchronous clear of both counters.
REQ-010 busy  output  1  a check is in progress (state != IDLE).
REQ-011 chk_done  output  1  one-cycle pulse; result of the latest check is valid.
REQ-012 chk_pass  output  1  1 = the latest sample matched the expected value.
REQ-013 exp_out  output  1  expected value of the latest accepted vector.
REQ-014 pass_cnt, fail_cnt  output  CNT_W each  running totals.

Function
REQ-015 FSM states: IDLE, SETTLE, DONE; IDLE->SETTLE on accept; SETTLE->DONE on the sample edge; DONE->IDLE unconditionally after one cycle.
REQ-016 vec_ready = 1 only in IDLE; accept = vec_valid && vec_ready at a rising edge.
REQ-017 On accept: latch vec_a/b/c; set exp_out = (a & b) | c; load settle counter with SETTLE_CYCLES.
REQ-018 Accept at edge k -> dut_out sampled at edge k+SETTLE_CYCLES; chk_done, chk_pass, and counter update visible in the following cycle (DONE state).
REQ-019 Next accept earliest at edge k+SETTLE_CYCLES+2; vec_valid held during SETTLE/DONE is ignored, not queued.
REQ-020 Compare uses four-state equality: X or Z on dut_out = fail.
REQ-021 chk_pass holds its value until the next sample edge; chk_done is high only in DONE.
REQ-022 Counters saturate at all-ones; never wrap.
REQ-023 clear zeroes both counters at the next edge; clear wins over a same-edge increment; FSM unaffected.
REQ-024 Stimulus inputs changing during SETTLE do not alter exp_out or the sample.

Reset
REQ-025 reset_n low: state = IDLE, settle counter 0, vec_ready = 1, busy = 0, chk_done = 0, chk_pass = 0, exp_out = 0, pass_cnt = 0, fail_cnt = 0.
REQ-026 Reset during SETTLE or DONE aborts the check; no counter update and no chk_done afterwards.

Structure
REQ-027 Shared package response_checker_pkg holds the state encodings (IDLE = 0, SETTLE = 1, DONE = 2), the expected-value function, and the SETTLE_CYCLES default.
REQ-028 One sub-module, settle_timer: 8-bit loadable down-counter with a zero flag, clock/reset_n as above.

Verification
REQ-029 a,b,c = 0,0,0 with dut_out = 0 -> chk_done at cycle 10 after accept, chk_pass = 1, pass_cnt = 1, exp_out = 0.
REQ-030 a,b,c = 1,1,1 with dut_out forced 0 -> chk_pass = 0, fail_cnt = 1, exp_out = 1.
REQ-031 vec_valid held high with 3 vectors (1,0,0; 0,0,1; 1,1,0) -> accepts spaced exactly 11 cycles apart; pass_cnt = 3 with a correct DUT.
REQ-032 CNT_W = 2 with 5 failing vectors -> fail_cnt sticks at 3.
REQ-033 reset_n pulsed low in cycle 4 of SETTLE -> no chk_done, counters 0, vec_ready = 1 immediately.
REQ-034 clear asserted on the same edge as a pass increment (pass_cnt = 2) -> pass_cnt = 0; dut_out = X at the sample -> fail counted.

Source files
------------

// File: rtl/response_checker_pkg.sv
// response_checker_pkg: shared state encoding, settle default and expected-value function.
package response_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int SETTLE_DEFAULT = 9;

    function automatic logic expected_out(input logic a, input logic b, input logic c);
        return (a & b) | c;
    endfunction

endpackage

// File: rtl/response_checker_settle_timer.sv
// settle_timer: 8-bit loadable down-counter that parks at zero and flags it.
module settle_timer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       zero
);

    assign zero = count == 8'd0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count <= 8'd0;
        else if (load)
            count <= load_val;
        else if (!zero)
            count <= count - 8'd1;
    end

endmodule

// File: rtl/response_checker.sv
// response_checker: applies one stimulus vector, waits SETTLE_CYCLES, samples the DUT
// response against (a & b) | c and keeps saturating pass/fail totals.
module response_checker
    import response_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_DEFAULT,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic             vec_a,
    input  logic             vec_b,
    input  logic             vec_c,
    input  logic             dut_out,
    input  logic             clear,
    output logic             busy,
    output logic             chk_done,
    output logic             chk_pass,
    output logic             exp_out,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    state_t     state;
    logic [7:0] count;
    logic       zero;
    logic       accept;
    logic       sample;
    logic       match;

    assign vec_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign chk_done  = state == DONE;
    assign accept    = vec_valid && vec_ready;
    // Timer is loaded with SETTLE_CYCLES at accept, so it reads 1 on the sample edge.
    assign sample    = state == SETTLE && (count == 8'd1 || zero);
    assign match     = dut_out === exp_out;

    settle_timer u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (accept),
        .load_val (8'(SETTLE_CYCLES)),
        .count    (count),
        .zero     (zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            chk_pass <= 1'b0;
            exp_out  <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            state <= accept ? SETTLE : sample ? DONE : state == DONE ? IDLE : state;
            if (accept)
                exp_out <= expected_out(vec_a, vec_b, vec_c);
            if (sample)
                chk_pass <= match;
            if (clear) begin
                pass_cnt <= '0;
                fail_cnt <= '0;
            end else if (sample) begin
                if (match && pass_cnt != '1)
                    pass_cnt <= pass_cnt + 1'b1;
                if (!match && fail_cnt != '1)
                    fail_cnt <= fail_cnt + 1'b1;
            end
        end
    end

endmodule
